// File: rtl/nios2_ocimem_arbiter.sv
// Arbiter for the single-port debug monitor RAM: JTAG host path vs CPU slave.
// Optional CPU write protection above PROT_BASE via OCIMEM_WRITE_PROTECT_EN.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   debugack          CPU is in debug mode (selects priority scheme)
//   jtag_*            level request, one-cycle ack, held read data
//   cpu_*             Avalon-style slave (read/write, waitrequest, readdata)
//   ram_*             registered address/data/strobes, read data RD_LAT later
//   prot_viol         sticky CPU write-protect violation (optional feature)
module nios2_ocimem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
`ifdef OCIMEM_WRITE_PROTECT_EN
    ,
    parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(8'hE0)
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              debugack,
    input  logic              jtag_req,
    input  logic              jtag_we,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [DATA_W-1:0] jtag_wdata,
    output logic              jtag_ack,
    output logic [DATA_W-1:0] jtag_rdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic              cpu_waitrequest,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
`ifdef OCIMEM_WRITE_PROTECT_EN
    output logic              prot_viol,
`endif
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              cpu_pend;
    logic              grant_j;
    logic              grant_c;
    logic              grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              prot_hit;
    logic              wait_last;

    logic              owner_cpu;
    logic              we_q;
    logic              rr_cpu;
    logic [SC_W-1:0]   starve_cnt;
    logic [1:0]        wait_cnt;

    assign cpu_pend  = cpu_read | cpu_write;
    assign grant     = grant_j | grant_c;
    assign sel_we    = grant_c ? cpu_write : jtag_we;
    assign sel_addr  = grant_c ? cpu_address : jtag_addr;
    assign sel_wdata = grant_c ? cpu_writedata : jtag_wdata;
    assign wait_last = (wait_cnt == WAIT_LAST);

`ifdef OCIMEM_WRITE_PROTECT_EN
    // Only non-debug CPU writes into the protected window are suppressed.
    assign prot_hit = grant_c & cpu_write & ~debugack
                    & (cpu_address >= PROT_BASE);
`else
    assign prot_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        grant_j   = 1'b0;
        grant_c   = 1'b0;
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (jtag_req && cpu_pend) begin
                    // Debug mode favours JTAG, bounded by the starve guard.
                    if (debugack) begin
                        if (starve_cnt == SC_MAX) begin
                            grant_c = 1'b1;
                        end else begin
                            grant_j = 1'b1;
                        end
                    end else if (rr_cpu) begin
                        grant_j = 1'b1;
                    end else begin
                        grant_c = 1'b1;
                    end
                end else if (jtag_req) begin
                    grant_j = 1'b1;
                end else if (cpu_pend) begin
                    grant_c = 1'b1;
                end
                if (grant_j || grant_c) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: state_nxt = we_q ? DONE : WAIT;
            WAIT: begin
                if (wait_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            jtag_ack        <= 1'b0;
            cpu_waitrequest <= 1'b1;
            ram_we          <= 1'b0;
            ram_re          <= 1'b0;
            ram_addr        <= '0;
            ram_wdata       <= '0;
            jtag_rdata      <= '0;
            cpu_readdata    <= '0;
            owner_cpu       <= 1'b0;
            we_q            <= 1'b0;
            rr_cpu          <= 1'b1;
            starve_cnt      <= '0;
            wait_cnt        <= '0;
`ifdef OCIMEM_WRITE_PROTECT_EN
            prot_viol       <= 1'b0;
`endif
        end else begin
            // Strobes are issued at the grant edge so they fill ACCESS.
            ram_we <= grant & sel_we & ~prot_hit;
            ram_re <= grant & ~sel_we;
            jtag_ack        <= (state_nxt == DONE) & ~owner_cpu;
            cpu_waitrequest <= ~((state_nxt == DONE) & owner_cpu);

            if (grant) begin
                owner_cpu <= grant_c;
                we_q      <= sel_we;
                ram_addr  <= sel_addr;
                ram_wdata <= sel_wdata;
                rr_cpu    <= grant_c;
            end

            if (grant_c) begin
                starve_cnt <= '0;
            end else if (grant_j && cpu_pend) begin
                if (starve_cnt != SC_MAX) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (state == IDLE && !cpu_pend) begin
                starve_cnt <= '0;
            end

            if (state == ACCESS) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 2'd1;
            end

            if (state == WAIT && wait_last) begin
                if (owner_cpu) begin
                    cpu_readdata <= ram_rdata;
                end else begin
                    jtag_rdata <= ram_rdata;
                end
            end

`ifdef OCIMEM_WRITE_PROTECT_EN
            if (prot_hit) begin
                prot_viol <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: doc/nios2_ocimem_arbiter.md
Name: nios2_ocimem_arbiter

Overview:
Arbitrates single-port on-chip debug monitor RAM between the JTAG debug host path (sysclk-domain command decode) and the CPU debug slave port. Each side is a single-outstanding request/acknowledge client. The block sequences RAM strobes, handles read latency, and returns data. Priority depends on CPU debug mode (debugack), with a starvation guard that protects the CPU.

Parameters:
ADDR_W, 8, RAM word address width
DATA_W, 32, RAM data width
RD_LAT, 1, RAM read latency in cycles (legal 1..3)
STARVE_MAX, 4, consecutive JTAG grants allowed while a CPU request is pending
PROT_BASE, 8'hE0, first CPU-write-protected address (used only with the optional feature)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
debugack  in  1  CPU is in debug mode
jtag_req  in  1  JTAG access request (level)
jtag_we  in  1  1=write, 0=read
jtag_addr  in  ADDR_W  JTAG word address
jtag_wdata  in  DATA_W  JTAG write data
jtag_ack  out  1  one-cycle completion pulse
jtag_rdata  out  DATA_W  read data, valid with jtag_ack, held until next JTAG read
cpu_read  in  1  CPU read request
cpu_write  in  1  CPU write request
cpu_address  in  ADDR_W  CPU word address
cpu_writedata  in  DATA_W  CPU write data
cpu_waitrequest  out  1  Avalon-style waitrequest
cpu_readdata  out  DATA_W  read data, valid when waitrequest=0 on a read
ram_addr  out  ADDR_W  registered RAM address
ram_wdata  out  DATA_W  registered RAM write data
ram_we  out  1  RAM write strobe
ram_re  out  1  RAM read strobe
ram_rdata  in  DATA_W  RAM read data, RD_LAT cycles after ram_re

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, port reset.
- Reset values:
  - jtag_ack=0, ram_we=0, ram_re=0
  - ram_addr=0, ram_wdata=0, jtag_rdata=0, cpu_readdata=0
  - cpu_waitrequest=1
  - FSM=IDLE, rr_last=CPU, starve_cnt=0
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: arbitrate among pending requests. CPU pending = cpu_read|cpu_write; cpu_write wins if both are set.
  - Only one requester pending: grant it.
  - Both pending, debugack=1: grant JTAG, unless starve_cnt==STARVE_MAX, in which case grant CPU.
  - Both pending, debugack=0: round-robin; grant the side opposite rr_last.
  - On grant: latch owner, we, addr, wdata into ram_addr/ram_wdata; update rr_last; go to ACCESS.
  - Later changes on the requester's inputs are ignored until DONE.
- starve_cnt:
  - Increments on a JTAG grant while the CPU is pending, saturating at STARVE_MAX.
  - Clears on any CPU grant, or when the CPU is not pending in IDLE.
- ACCESS (1 cycle): drive ram_we=we or ram_re=~we for exactly one cycle. Write goes to DONE; read goes to WAIT.
- WAIT (RD_LAT cycles): sample ram_rdata on the last WAIT cycle into jtag_rdata or cpu_readdata (owner only), then go to DONE.
- DONE (1 cycle), then go to IDLE:
  - JTAG owner: jtag_ack=1.
  - CPU owner: cpu_waitrequest=0.
- cpu_waitrequest is 0 only in DONE with owner=CPU; it is 1 at all other times, including while idle.
- Latency, counted from the grant cycle (cycle 0): write completes at cycle 2; read completes at cycle 2+RD_LAT. No pipelining: the next grant is no earlier than the cycle after DONE.
- JTAG handshake: the requester drops jtag_req the cycle after jtag_ack. A req still high in the IDLE cycle following DONE is treated as a new request.
- CPU handshake: Avalon. The CPU holds the request until waitrequest=0, then deasserts or presents the next transfer.
- Reset mid-operation: the access is aborted. No ack and no waitrequest drop are produced. A pending ram_we is deasserted on the reset edge (at most one write strobe may already have been issued). Captured read data is discarded.
- Read-data hold: the non-owner's read-data register is never modified.

Optional Feature:
OCIMEM_WRITE_PROTECT_EN
- Defined:
  - A CPU write with cpu_address>=PROT_BASE while debugack=0 completes normally (cpu_waitrequest drops at cycle 2) but ram_we stays 0.
  - Sticky output prot_viol (1 bit, reset 0) is set and is cleared only by reset.
  - JTAG writes and debug-mode CPU writes are unaffected.
- Undefined: no prot_viol port; all writes reach RAM.

Test Plan:
- JTAG write addr 0x10 data 0xDEADBEEF, then JTAG read 0x10 (RD_LAT=1) -> ram_we one pulse at cycle 1; jtag_ack at cycle 2 for the write and at cycle 3 for the read; jtag_rdata=0xDEADBEEF.
- CPU read and JTAG read asserted together, debugack=0, rr_last=CPU -> JTAG served first; CPU waitrequest held until the second access completes; the next simultaneous pair grants CPU first.
- debugack=1, jtag_req held continuously, cpu_read pending, STARVE_MAX=4 -> exactly 4 JTAG acks, then a CPU grant; cpu_waitrequest=0 on that CPU's DONE.
- RD_LAT=3, CPU read addr 0x05 with RAM content 0x12345678 -> cpu_waitrequest=0 exactly at cycle 5; cpu_readdata=0x12345678; jtag_rdata unchanged.
- Reset asserted during WAIT of a JTAG read -> no jtag_ack; outputs at reset values next cycle; a fresh request completes normally.
- With OCIMEM_WRITE_PROTECT_EN, debugack=0, CPU write 0xE4 -> no ram_we, prot_viol=1, waitrequest drops at cycle 2; repeating with debugack=1 -> ram_we pulses.
